pipeline_bypass_unit: RTL and testbench
=======================================

// Module: pipeline_bypass_unit
//
// PURPOSE
//  Parametrised operand-forwarding and load-use hazard unit for the pipelined core.
//  Tracks in-flight register writers in the post-decode stages (EX..WB by default).
//  Selects the youngest forwardable result per source port and raises want_stall
//  while a needed result is not yet produced. Inserts its own bubble into stage 0.
//  Generalises the fixed two-port, three-stage, single-latency bypass in the datapath:
//  configurable stage count, read-port count and per-instruction result latency.
//
// PARAMETERS
//  XLEN        32  data width
//  STAGES      3   tracked post-decode stages; index 0 = EX, STAGES-1 = WB
//  READ_PORTS  2   source operand ports
//  REG_AW      5   register address width
//  (RS_W = $clog2(STAGES), derived, not overridable)
//
// PORTS
//  clock            in   1                  core clock
//  reset            in   1                  async, active-high
//  issue_valid      in   1                  ID holds an instruction this cycle
//  issue_kill       in   1                  drop the ID instruction (branch bubble)
//  issue_writes     in   1                  ID instruction writes rd
//  issue_rd         in   REG_AW             ID destination register
//  issue_ready_stg  in   RS_W               stage index where its result first exists
//  kill_mask        in   STAGES             squash tracked entry in stage i at this edge
//  stage_result     in   STAGES*XLEN        result currently produced in stage i
//  rs_addr          in   READ_PORTS*REG_AW  source register per port
//  rs_uses          in   READ_PORTS         port value is actually consumed
//  rs_regfile_data  in   READ_PORTS*XLEN    raw register-file read per port
//  rs_data          out  READ_PORTS*XLEN    forwarded operand per port
//  want_stall       out  1                  hold IF/ID; bubble is inserted here
//  stall_count      out  32                 saturating count of stalled cycles
//
// BEHAVIOUR
//  - Per-stage state: valid, rd, ready_stg. Entry is "live" iff valid && rd!=0.
//    issue_writes=0 or rd=x0 enters as not live.
//  - Every edge: stage[i+1] <= stage[i], valid cleared if kill_mask[i]. No back-pressure.
//    stage[0].valid <= issue_valid && issue_writes && !issue_kill && !want_stall.
//    The entry in stage STAGES-1 retires (register file writes it at that edge).
//  - issue_ready_stg >= STAGES is treated as STAGES-1.
//  - Port p match: lowest i with live[i] && rd[i]==rs_addr[p]. Only youngest matters.
//      no match            -> rs_data[p] = rs_regfile_data[p]
//      match, ready_stg<=i -> rs_data[p] = stage_result[i]
//      match, ready_stg>i  -> rs_data[p] = rs_regfile_data[p]; port is "blocked"
//    rs_addr[p]==0 never matches, so rs_data[p] = rs_regfile_data[p].
//  - want_stall = OR over p of (blocked[p] && rs_uses[p]). Combinational, same cycle.
//  - Blocked port with rs_uses=0: no stall; data is don't-care.
//  - kill_mask applies to the edge it is sampled at; a killed entry never forwards after.
//  - stall_count increments on each edge with want_stall=1; saturates at 32'hFFFF_FFFF.
//  - Latency: forwarding and stall are combinational. A default load (ready_stg=1)
//    followed by a dependent consumer stalls exactly 1 cycle.
//  - Reset, including mid-operation: all valid=0, stall_count=0.
//    Hence want_stall=0 and rs_data = rs_regfile_data until new issues.
//
// TESTING
//  1 ALU fwd: issue x5 rdy0; next cycle stage_result[0]=32'h11, read x5 uses=1
//    -> rs_data=32'h11, want_stall=0.
//  2 load-use: issue x6 rdy1; next cycle read x6 uses=1 -> want_stall=1 one cycle;
//    then stage_result[1]=32'hDEADBEEF forwarded; stall_count=1.
//  3 youngest wins: x7 in stage0 (res 32'h2) and stage2 (res 32'h1) -> rs_data=32'h2.
//  4 x0/unused: rd=0 writer, read x0 -> regfile data, no stall.
//    Load-use with rs_uses=0 -> no stall.
//  5 kill: issue_kill=1 with x9 rdy1 -> later read x9 gives regfile data.
//    kill_mask[0] on x9 in EX also drops it.
//  6 reset mid-flight: 3 live entries, pulse reset -> want_stall=0, stall_count=0,
//    rs_data=regfile data.

Source files
------------

// File: rtl/pipeline_bypass_unit.sv
// Operand-forwarding and load-use hazard unit.
// Tracks in-flight register writers in the post-decode stages (index 0 = EX,
// STAGES-1 = WB), forwards the youngest available result per read port and
// requests a stall while a needed result has not been produced yet.
module pipeline_bypass_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STAGES     = 3,
  parameter int unsigned READ_PORTS = 2,
  parameter int unsigned REG_AW     = 5,
  localparam int unsigned RS_W      = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         issue_valid,
  input  logic                         issue_kill,
  input  logic                         issue_writes,
  input  logic [REG_AW-1:0]            issue_rd,
  input  logic [RS_W-1:0]              issue_ready_stg,
  input  logic [STAGES-1:0]            kill_mask,
  input  logic [STAGES*XLEN-1:0]       stage_result,
  input  logic [READ_PORTS*REG_AW-1:0] rs_addr,
  input  logic [READ_PORTS-1:0]        rs_uses,
  input  logic [READ_PORTS*XLEN-1:0]   rs_regfile_data,
  output logic [READ_PORTS*XLEN-1:0]   rs_data,
  output logic                         want_stall,
  output logic [31:0]                  stall_count
);

  logic [STAGES-1:0]     valid_q, valid_d;
  logic [REG_AW-1:0]     rd_q  [STAGES];
  logic [REG_AW-1:0]     rd_d  [STAGES];
  logic [RS_W-1:0]       rdy_q [STAGES];
  logic [RS_W-1:0]       rdy_d [STAGES];
  logic [STAGES-1:0]     live;
  logic [READ_PORTS-1:0] blocked;
  logic [RS_W-1:0]       issue_rdy_clamped;
  logic [31:0]           stall_count_q, stall_count_d;

  // Ready-stage indices past the last tracked stage collapse onto WB.
  always_comb begin
    issue_rdy_clamped = issue_ready_stg;
    if (32'(issue_ready_stg) >= STAGES) begin
      issue_rdy_clamped = RS_W'(STAGES - 1);
    end
  end

  // An entry can forward only if it is valid and targets a real register (not x0).
  always_comb begin
    live = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      live[i] = valid_q[i] && (rd_q[i] != '0);
    end
  end

  // Per port: the first (youngest) live match decides; forward if produced, else block.
  always_comb begin
    logic hit;
    rs_data = rs_regfile_data;
    blocked = '0;
    hit     = 1'b0;
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      hit = 1'b0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        if (!hit && live[i] && (rd_q[i] == rs_addr[p*REG_AW +: REG_AW])) begin
          hit = 1'b1;
          if (32'(rdy_q[i]) <= i) begin
            rs_data[p*XLEN +: XLEN] = stage_result[i*XLEN +: XLEN];
          end else begin
            blocked[p] = 1'b1;
          end
        end
      end
    end
  end

  // Stall only when a blocked port is actually consumed.
  always_comb begin
    want_stall = |(blocked & rs_uses);
  end

  // Advance the tracking pipe; a stall turns the stage-0 slot into a bubble.
  always_comb begin
    valid_d[0] = issue_valid && issue_writes && !issue_kill && !want_stall;
    rd_d[0]    = issue_rd;
    rdy_d[0]   = issue_rdy_clamped;
    for (int unsigned i = 1; i < STAGES; i++) begin
      valid_d[i] = valid_q[i-1] && !kill_mask[i-1];
      rd_d[i]    = rd_q[i-1];
      rdy_d[i]   = rdy_q[i-1];
    end
    stall_count_d = stall_count_q;
    if (want_stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q       <= '0;
      stall_count_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        rd_q[i]  <= '0;
        rdy_q[i] <= '0;
      end
    end else begin
      valid_q       <= valid_d;
      rd_q          <= rd_d;
      rdy_q         <= rdy_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_bypass_unit.sv
// Directed, table-driven bench for pipeline_bypass_unit (default parameters).
// Each table row is one clock cycle: inputs are driven just after the rising
// edge and outputs are compared at the falling edge.
module tb_pipeline_bypass_unit;

  localparam logic [31:0] RF0 = 32'hF0F0_0000;
  localparam logic [31:0] RF1 = 32'hF1F1_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid, issue_kill, issue_writes;
  logic [4:0]  issue_rd;
  logic [1:0]  issue_ready_stg;
  logic [2:0]  kill_mask;
  logic [95:0] stage_result;
  logic [9:0]  rs_addr;
  logic [1:0]  rs_uses;
  logic [63:0] rs_regfile_data;
  logic [63:0] rs_data;
  logic        want_stall;
  logic [31:0] stall_count;

  int checks   = 0;
  int failures = 0;

  pipeline_bypass_unit #(.XLEN(32), .STAGES(3), .READ_PORTS(2), .REG_AW(5)) dut (
    .clock           (clock),
    .reset           (reset),
    .issue_valid     (issue_valid),
    .issue_kill      (issue_kill),
    .issue_writes    (issue_writes),
    .issue_rd        (issue_rd),
    .issue_ready_stg (issue_ready_stg),
    .kill_mask       (kill_mask),
    .stage_result    (stage_result),
    .rs_addr         (rs_addr),
    .rs_uses         (rs_uses),
    .rs_regfile_data (rs_regfile_data),
    .rs_data         (rs_data),
    .want_stall      (want_stall),
    .stall_count     (stall_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        iv, ik, iw;
    logic [4:0]  ird;
    logic [1:0]  irdy;
    logic [2:0]  km;
    logic [31:0] s0, s1, s2;
    logic [4:0]  a0, a1;
    logic [1:0]  u;
    logic [31:0] e0, e1;
    logic        es;
    logic [31:0] ecnt;
    logic [1:0]  dchk;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, input logic ik, input logic iw,
                              input logic [4:0] ird, input logic [1:0] irdy,
                              input logic [2:0] km, input logic [31:0] s0,
                              input logic [31:0] s1, input logic [31:0] s2,
                              input logic [4:0] a0, input logic [4:0] a1,
                              input logic [1:0] u, input logic [31:0] e0,
                              input logic [31:0] e1, input logic es,
                              input logic [31:0] ecnt, input logic [1:0] dchk);
    vec_t v;
    v.iv = iv; v.ik = ik; v.iw = iw; v.ird = ird; v.irdy = irdy; v.km = km;
    v.s0 = s0; v.s1 = s1; v.s2 = s2; v.a0 = a0; v.a1 = a1; v.u = u;
    v.e0 = e0; v.e1 = e1; v.es = es; v.ecnt = ecnt; v.dchk = dchk;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(posedge clock);
    #1;
    issue_valid     = v.iv;
    issue_kill      = v.ik;
    issue_writes    = v.iw;
    issue_rd        = v.ird;
    issue_ready_stg = v.irdy;
    kill_mask       = v.km;
    stage_result    = {v.s2, v.s1, v.s0};
    rs_addr         = {v.a1, v.a0};
    rs_uses         = v.u;
    @(negedge clock);
    chk($sformatf("row%0d want_stall", idx), {31'd0, want_stall}, {31'd0, v.es});
    chk($sformatf("row%0d stall_count", idx), stall_count, v.ecnt);
    if (v.dchk[0]) chk($sformatf("row%0d rs_data0", idx), rs_data[31:0], v.e0);
    if (v.dchk[1]) chk($sformatf("row%0d rs_data1", idx), rs_data[63:32], v.e1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    issue_valid     = 1'b0;
    issue_kill      = 1'b0;
    issue_writes    = 1'b0;
    issue_rd        = '0;
    issue_ready_stg = '0;
    kill_mask       = '0;
    stage_result    = '0;
    rs_addr         = '0;
    rs_uses         = '0;
    rs_regfile_data = {RF1, RF0};

    //          iv ik iw rd  rdy km     s0            s1            s2           a0  a1  u      e0            e1            es ecnt dchk
    vecs.push_back(mk(0, 0, 0, 0,  0, 3'b000, 32'h0,        32'h0,        32'h0,       5,  0,  2'b11, RF0,          RF1,          0, 0,  2'b11));
    vecs.push_back(mk(1, 0, 1, 5,  0, 3'b000, 32'h0,        32'h0,        32'h0,       5,  0,  2'b11, RF0,          RF1,          0, 0,  2'b11));
    vecs.push_back(mk(1, 0, 1, 6,  1, 3'b000, 32'h11,       32'h0,        32'h0,       5,  3,  2'b11, 32'h11,       RF1,          0, 0,  2'b11));
    vecs.push_back(mk(1, 0, 0, 8,  0, 3'b000, 32'h0,        32'h55,       32'h0,       6,  5,  2'b11, RF0,          32'h55,       1, 0,  2'b11));
    vecs.push_back(mk(1, 0, 0, 8,  0, 3'b000, 32'h0,        32'hDEADBEEF, 32'h22,      6,  5,  2'b11, 32'hDEADBEEF, 32'h22,       0, 1,  2'b11));
    vecs.push_back(mk(1, 0, 1, 7,  0, 3'b000, 32'h0,        32'h0,        32'h66,      6,  0,  2'b11, 32'h66,       RF1,          0, 1,  2'b11));
    vecs.push_back(mk(1, 0, 1, 1,  0, 3'b000, 32'h77,       32'h0,        32'h0,       7,  9,  2'b01, 32'h77,       RF1,          0, 1,  2'b11));
    vecs.push_back(mk(1, 0, 1, 7,  0, 3'b000, 32'h10,       32'h71,       32'h0,       7,  1,  2'b11, 32'h71,       32'h10,       0, 1,  2'b11));
    vecs.push_back(mk(0, 0, 0, 0,  0, 3'b000, 32'h2,        32'h1111,     32'h1,       7,  1,  2'b11, 32'h2,        32'h1111,     0, 1,  2'b11));
    vecs.push_back(mk(1, 0, 1, 0,  0, 3'b000, 32'h0,        32'h2222,     32'h0,       0,  7,  2'b11, RF0,          32'h2222,     0, 1,  2'b11));
    vecs.push_back(mk(1, 0, 1, 10, 2, 3'b000, 32'h0,        32'h0,        32'h3333,    0,  7,  2'b11, RF0,          32'h3333,     0, 1,  2'b11));
    vecs.push_back(mk(0, 0, 0, 0,  0, 3'b000, 32'h0,        32'h0,        32'h0,       10, 2,  2'b10, 32'h0,        RF1,          0, 1,  2'b10));
    vecs.push_back(mk(0, 0, 0, 0,  0, 3'b000, 32'h0,        32'h0,        32'h0,       10, 2,  2'b11, RF0,          RF1,          1, 1,  2'b11));
    vecs.push_back(mk(1, 0, 1, 11, 3, 3'b000, 32'h0,        32'h0,        32'hCAFE,    10, 10, 2'b11, 32'hCAFE,     32'hCAFE,     0, 2,  2'b11));
    vecs.push_back(mk(1, 0, 1, 15, 0, 3'b000, 32'h0,        32'h0,        32'h0,       11, 0,  2'b01, RF0,          RF1,          1, 2,  2'b11));
    vecs.push_back(mk(0, 0, 0, 0,  0, 3'b000, 32'hBAD,      32'h0,        32'h0,       11, 15, 2'b11, RF0,          RF1,          1, 3,  2'b11));
    vecs.push_back(mk(0, 0, 0, 0,  0, 3'b000, 32'h0,        32'h0,        32'hC1A3,    11, 0,  2'b01, 32'hC1A3,     RF1,          0, 4,  2'b11));
    vecs.push_back(mk(1, 1, 1, 9,  1, 3'b000, 32'h0,        32'h0,        32'h0,       11, 0,  2'b01, RF0,          RF1,          0, 4,  2'b11));
    vecs.push_back(mk(1, 0, 1, 9,  0, 3'b000, 32'h0,        32'h0,        32'h0,       9,  0,  2'b01, RF0,          RF1,          0, 4,  2'b11));
    vecs.push_back(mk(0, 0, 0, 0,  0, 3'b001, 32'h99,       32'h0,        32'h0,       9,  0,  2'b01, 32'h99,       RF1,          0, 4,  2'b11));
    vecs.push_back(mk(0, 0, 0, 0,  0, 3'b000, 32'h99,       32'h98,       32'h97,      9,  9,  2'b11, RF0,          RF1,          0, 4,  2'b11));
    vecs.push_back(mk(1, 0, 1, 12, 1, 3'b000, 32'h0,        32'h0,        32'h0,       0,  0,  2'b00, RF0,          RF1,          0, 4,  2'b11));
    vecs.push_back(mk(1, 0, 1, 13, 1, 3'b000, 32'h0,        32'h0,        32'h0,       0,  0,  2'b00, RF0,          RF1,          0, 4,  2'b11));
    vecs.push_back(mk(1, 0, 1, 14, 1, 3'b000, 32'h0,        32'h0,        32'h0,       0,  0,  2'b00, RF0,          RF1,          0, 4,  2'b11));
    vecs.push_back(mk(0, 0, 0, 0,  0, 3'b000, 32'h0,        32'h0,        32'h12,      14, 12, 2'b11, RF0,          32'h12,       1, 4,  2'b11));

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[k]) apply(vecs[k], k);

    // Reset while three writers are in flight and a stall is active.
    #1 reset = 1'b1;
    #2;
    chk("rst_async want_stall", {31'd0, want_stall}, 32'd0);
    chk("rst_async stall_count", stall_count, 32'd0);
    chk("rst_async rs_data1", rs_data[63:32], RF1);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("post_rst want_stall", {31'd0, want_stall}, 32'd0);
    chk("post_rst stall_count", stall_count, 32'd0);
    chk("post_rst rs_data0", rs_data[31:0], RF0);
    chk("post_rst rs_data1", rs_data[63:32], RF1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
